opl3_i2s_tx: RTL and testbench

OPL3_I2S_TX -- requirements
Module: opl3_i2s_tx

---
 rtl/opl3_i2s_tx.sv | 98 +++++++++
 tb/tb_opl3_i2s_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/opl3_i2s_tx.sv
// I2S transmitter: one-pair hold buffer feeding a 64-bit L/R frame,
// 32-bit slots with the standard one-bclk data delay.
module opl3_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int BCLK_HALF  = 2
) (
    input  logic                  clk,
    input  logic                  ic_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_l,
    input  logic [DATA_WIDTH-1:0] sample_r,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int DIV_MAX = 2 * BCLK_HALF - 1;
    localparam int DIV_W   = $clog2(2 * BCLK_HALF);

    logic [DIV_W-1:0]      div_cnt;
    logic [5:0]            bit_cnt;
    logic                  div_wrap;
    logic                  load;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] frame_l;
    logic [DATA_WIDTH-1:0] frame_r;
    logic [4:0]            slot;
    logic [4:0]            bit_idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  sdata_d;

    assign div_wrap = (div_cnt == DIV_W'(DIV_MAX));
    assign load     = (div_cnt == '0) && (bit_cnt == '0);

    // Slot 0 is the I2S delay bit; data occupies slots 1..DATA_WIDTH MSB first.
    always_comb begin
        slot    = bit_cnt[4:0];
        bit_idx = 5'(DATA_WIDTH) - slot;
        word    = bit_cnt[5] ? frame_r : frame_l;
        sdata_d = 1'b0;
        if ((slot != 5'd0) && (slot <= 5'(DATA_WIDTH)))
            sdata_d = word[bit_idx];
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            div_cnt   <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap)
                bit_cnt <= bit_cnt + 6'd1;
            i2s_bclk  <= (div_cnt >= DIV_W'(BCLK_HALF));
            i2s_lrclk <= bit_cnt[5];
            i2s_sdata <= sdata_d;
            overrun   <= sample_valid && hold_full && !load;
            underrun  <= load && !hold_full && !sample_valid;
        end
    end

    // Frame pair is only touched at the load cycle, so it is stable all frame.
    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            frame_l   <= '0;
            frame_r   <= '0;
        end else if (load) begin
            if (hold_full) begin
                frame_l   <= hold_l;
                frame_r   <= hold_r;
                hold_full <= sample_valid;
                if (sample_valid) begin
                    hold_l <= sample_l;
                    hold_r <= sample_r;
                end
            end else if (sample_valid) begin
                frame_l <= sample_l;
                frame_r <= sample_r;
            end
        end else if (sample_valid) begin
            hold_l    <= sample_l;
            hold_r    <= sample_r;
            hold_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_opl3_i2s_tx.sv
// Bench for opl3_i2s_tx: per-cycle comparison against a frame-level
// model plus decoded-word checks for directed and random traffic.
module tb_opl3_i2s_tx;

    localparam int DW = 24;
    localparam int BH = 2;
    localparam int P2 = 2 * BH;
    localparam int FL = P2 * 64;

    logic          clk = 1'b0;
    logic          ic_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_l = '0;
    logic [DW-1:0] sample_r = '0;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          overrun;
    logic          underrun;

    opl3_i2s_tx #(.DATA_WIDTH(DW), .BCLK_HALF(BH)) dut (
        .clk          (clk),
        .ic_n         (ic_n),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int            cyc;
    logic          m_full;
    logic [DW-1:0] m_hl, m_hr, m_fl, m_fr;
    logic [DW-1:0] dec_l, dec_r;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        m_full = 1'b0;
        m_hl   = '0;
        m_hr   = '0;
        m_fl   = '0;
        m_fr   = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_bclk"}, 32'(i2s_bclk), 0);
        chk({tag, "_lrclk"}, 32'(i2s_lrclk), 0);
        chk({tag, "_sdata"}, 32'(i2s_sdata), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_und"}, 32'(underrun), 0);
    endtask

    // One clk: apply inputs, step the model, then compare all outputs.
    task automatic tick(input logic v, input logic [DW-1:0] l,
                        input logic [DW-1:0] r);
        int            div, bitn, s;
        logic          ld, e_ovr, e_und, e_sd;
        logic [DW-1:0] w;
        sample_valid = v;
        sample_l     = l;
        sample_r     = r;
        @(posedge clk);
        div   = cyc % P2;
        bitn  = (cyc / P2) % 64;
        s     = bitn % 32;
        ld    = (cyc % FL) == 0;
        e_ovr = v && m_full && !ld;
        e_und = ld && !m_full && !v;
        if (ld) begin
            if (m_full) begin
                m_fl   = m_hl;
                m_fr   = m_hr;
                m_full = v;
                if (v) begin
                    m_hl = l;
                    m_hr = r;
                end
            end else if (v) begin
                m_fl = l;
                m_fr = r;
            end
        end else if (v) begin
            m_hl   = l;
            m_hr   = r;
            m_full = 1'b1;
        end
        w    = (bitn < 32) ? m_fl : m_fr;
        e_sd = (s >= 1 && s <= DW) ? w[DW-s] : 1'b0;
        #1;
        chk("bclk", 32'(i2s_bclk), 32'(div >= BH));
        chk("lrclk", 32'(i2s_lrclk), 32'(bitn >= 32));
        chk("sdata", 32'(i2s_sdata), 32'(e_sd));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("underrun", 32'(underrun), 32'(e_und));
        if (div == BH && s >= 1 && s <= DW) begin
            if (bitn < 32) dec_l[DW-s] = i2s_sdata;
            else           dec_r[DW-s] = i2s_sdata;
        end
        cyc++;
        sample_valid = 1'b0;
    endtask

    // One whole frame with up to two sample strobes (offset -1 = none).
    task automatic run_frame(input int oa, input logic [DW-1:0] la,
                             input logic [DW-1:0] ra, input int ob,
                             input logic [DW-1:0] lb, input logic [DW-1:0] rb);
        for (int k = 0; k < FL; k++) begin
            if (k == oa)      tick(1'b1, la, ra);
            else if (k == ob) tick(1'b1, lb, rb);
            else              tick(1'b0, '0, '0);
        end
    endtask

    initial begin
        logic [DW-1:0] base, prev_l, prev_r, cur_l, cur_r;
        model_reset();
        dec_l = '0;
        dec_r = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        ic_n = 1'b1;

        // Held sample goes out in the following frame.
        run_frame(1, 24'h800001, 24'h7FFFFF, -1, '0, '0);
        chk("f0_dec_l", 32'(dec_l), 32'h0);
        run_frame(-1, '0, '0, -1, '0, '0);
        chk("f1_dec_l", 32'(dec_l), 32'h800001);
        chk("f1_dec_r", 32'(dec_r), 32'h7FFFFF);

        // Underrun retransmits; then two strobes in one frame overrun.
        run_frame(50, 24'h000001, 24'h0000AA, 120, 24'h000002, 24'h0000BB);
        chk("f2_retx_l", 32'(dec_l), 32'h800001);
        run_frame(-1, '0, '0, -1, '0, '0);
        chk("f3_newest_l", 32'(dec_l), 32'h000002);
        chk("f3_newest_r", 32'(dec_r), 32'h0000BB);

        // Strobe on the load cycle with an empty hold goes out immediately.
        run_frame(0, 24'h123456, 24'h654321, -1, '0, '0);
        chk("f4_direct_l", 32'(dec_l), 32'h123456);
        chk("f4_direct_r", 32'(dec_r), 32'h654321);

        for (int f = 0; f < 20; f++) begin
            int oa, ob;
            oa = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, FL - 1));
            ob = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
            if (f % 5 == 0) oa = 0;
            run_frame(oa, DW'($urandom), DW'($urandom),
                      ob, DW'($urandom), DW'($urandom));
        end

        // Mid-frame asynchronous reset near bit 40.
        for (int k = 0; k < 40 * P2 + 2; k++) begin
            if (k == 10) tick(1'b1, DW'($urandom), DW'($urandom));
            else         tick(1'b0, '0, '0);
        end
        #2 ic_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("rst_hold");
        @(negedge clk);
        ic_n = 1'b1;
        model_reset();

        // Ramp: one strobe per frame, output lags input by one frame.
        base   = DW'($urandom);
        prev_l = '0;
        prev_r = '0;
        for (int f = 0; f <= 100; f++) begin
            cur_l = base + DW'(f * 4099);
            cur_r = ~cur_l;
            run_frame(100, cur_l, cur_r, -1, '0, '0);
            if (f >= 1) begin
                chk("ramp_l", 32'(dec_l), 32'(prev_l));
                chk("ramp_r", 32'(dec_r), 32'(prev_r));
            end
            prev_l = cur_l;
            prev_r = cur_r;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
